digi_ota_decoder: RTL

//  Digital read-back end of the Digi OTA cell. The cell emits a tri-state pulse

---
 rtl/digi_ota_if.sv | 14 +
 rtl/digi_ota_decoder.sv | 109 ++++++++++
 2 files changed

// File: rtl/digi_ota_if.sv
// Result channel of the Digi OTA read-back decoder: a signed code and an activity count
// behind a valid/ready handshake.
interface digi_ota_if #(
  parameter int WIN_LOG2 = 8,
  parameter int CODE_W   = WIN_LOG2 + 2
);
  logic                     code_valid;
  logic                     code_ready;
  logic signed [CODE_W-1:0] code;
  logic [WIN_LOG2:0]        act_cnt;

  modport master (output code_valid, output code, output act_cnt, input code_ready);
  modport slave  (input code_valid, input code, input act_cnt, output code_ready);
endinterface

// File: rtl/digi_ota_decoder.sv
// Digi OTA read-back: synchronises the tri-state Out/EN pulse stream and integrates it
// over a 2**WIN_LOG2-sample window into a signed differential code plus activity count.
module digi_ota_decoder #(
  parameter int WIN_LOG2    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CODE_W      = WIN_LOG2 + 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        ota_out,
  input  logic        ota_en,
  input  logic        start,
  input  logic        cont,
  output logic        busy,
  digi_ota_if.master  code_if
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]               state;
  logic [SYNC_STAGES-1:0]   out_sync;
  logic [SYNC_STAGES-1:0]   en_sync;
  logic                     out_s;
  logic                     en_s;
  logic [WIN_LOG2-1:0]      win_cnt;
  logic signed [CODE_W-1:0] acc;
  logic [WIN_LOG2:0]        act;
  logic signed [CODE_W-1:0] acc_next;
  logic [WIN_LOG2:0]        act_next;

  // Out is only meaningful while EN is high; a floating pad contributes nothing.
  function automatic logic signed [CODE_W-1:0] delta(input logic en, input logic out);
    if (!en)
      return '0;
    else if (out)
      return {{(CODE_W-1){1'b0}}, 1'b1};
    else
      return '1;
  endfunction

  assign out_s = out_sync[SYNC_STAGES-1];
  assign en_s  = en_sync[SYNC_STAGES-1];
  assign busy  = (state == ACQ);

  always_comb begin
    acc_next = acc + delta(en_s, out_s);
    act_next = act + {{WIN_LOG2{1'b0}}, en_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sync           <= '0;
      en_sync            <= '0;
      state              <= IDLE;
      win_cnt            <= '0;
      acc                <= '0;
      act                <= '0;
      code_if.code_valid <= 1'b0;
      code_if.code       <= '0;
      code_if.act_cnt    <= '0;
    end else begin
      // Input synchroniser stage boundary: pads enter at [0], samples leave at the top.
      out_sync <= {out_sync[SYNC_STAGES-2:0], ota_out};
      en_sync  <= {en_sync[SYNC_STAGES-2:0], ota_en};

      if (!ena) begin
        state              <= IDLE;
        code_if.code_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= ACQ;
              win_cnt <= '0;
              acc     <= '0;
              act     <= '0;
            end
          end
          ACQ: begin
            acc     <= acc_next;
            act     <= act_next;
            win_cnt <= win_cnt + WIN_LOG2'(1);
            // Last sample of the window is folded in on the same edge that publishes it.
            if (&win_cnt) begin
              state              <= HOLD;
              code_if.code       <= acc_next;
              code_if.act_cnt    <= act_next;
              code_if.code_valid <= 1'b1;
            end
          end
          HOLD: begin
            if (code_if.code_ready) begin
              code_if.code_valid <= 1'b0;
              win_cnt            <= '0;
              acc                <= '0;
              act                <= '0;
              state              <= cont ? ACQ : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
